// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response port plus the
// core-facing instruction handshake and redirect/halt controls.
// master = fetch_unit side, slave = memory/core side.
interface fetch_unit_if #(
    parameter int PC_W = 8
) ();
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [15:0]     imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [15:0]     instruction;
    logic [PC_W-1:0] instr_pc;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output instr_valid, instruction, instr_pc,
        input  instr_ready,
        input  redirect, redirect_pc,
        output halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  instr_valid, instruction, instr_pc,
        output instr_ready,
        output redirect, redirect_pc,
        input  halted
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, credit-limited in-order fetch from
// instruction memory, DEPTH-entry prefetch queue, valid/ready delivery
// to the core, redirect with flush of in-flight fetches.
// Optional feature macro: FETCH_HALT_EN (halt on opcode 6'b111111).
//
// state   | meaning
// --------+--------------------------------------------------------
// S_FETCH | normal fetching, responses pushed into the queue
// S_FLUSH | after redirect: no requests, responses dropped until
//         | the outstanding count drains to zero
// S_HALT  | halt opcode consumed: no requests, responses dropped
module fetch_unit #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_unit_if.master   bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW:0] L_DEPTH = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FLUSH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [CW-1:0]   r_out_cnt;
    logic [CW-1:0]   w_out_nxt;
    logic [CW-1:0]   r_q_cnt;
    logic [AW-1:0]   r_q_rd;
    logic [AW-1:0]   r_q_wr;
    logic [15:0]     r_q_data [DEPTH];
    logic [PC_W-1:0] r_q_pc   [DEPTH];

    logic            w_req;
    logic            w_gnt_fire;
    logic            w_rsp;
    logic            w_push;
    logic            w_pop;
    logic            w_qclr;
    logic            w_halt_hs;
    logic [CW:0]     w_used;
    logic [PC_W-1:0] w_rsp_pc;

    assign w_pop = (r_q_cnt != '0) & bus.instr_ready;

    // A slot popped this cycle is free again, so it counts as credit now;
    // this is what lets DEPTH=2 stream one word per cycle.
    assign w_used = {1'b0, r_out_cnt} + {1'b0, r_q_cnt} - {{CW{1'b0}}, w_pop};

    // Reset gates the request so the port is quiet while rst_n is low.
    assign w_req      = (r_state == S_FETCH) & rst_n & (w_used < L_DEPTH);
    assign w_gnt_fire = w_req & bus.imem_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp = bus.imem_rvalid & (r_out_cnt != '0);

    // In S_FETCH every outstanding grant was issued to consecutive addresses
    // ending at r_pc-1, so the oldest one is r_pc - outstanding.
    assign w_rsp_pc = r_pc - PC_W'(r_out_cnt);

`ifdef FETCH_HALT_EN
    assign w_halt_hs  = w_pop & (r_q_data[r_q_rd][15:10] == 6'b111111);
    assign bus.halted = (r_state == S_HALT);
`else
    assign w_halt_hs  = 1'b0;
    assign bus.halted = 1'b0;
`endif

    assign w_qclr    = bus.redirect | w_halt_hs;
    assign w_push    = w_rsp & (r_state == S_FETCH) & ~w_qclr;
    assign w_out_nxt = r_out_cnt + {{(CW-1){1'b0}}, w_gnt_fire}
                                 - {{(CW-1){1'b0}}, w_rsp};

    // Next-state logic; redirect overrides everything else.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: if (w_halt_hs) w_state_nxt = S_HALT;
            S_FLUSH: if (w_out_nxt == '0) w_state_nxt = S_FETCH;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_FETCH;
        endcase
        if (bus.redirect) begin
            w_state_nxt = (w_out_nxt != '0) ? S_FLUSH : S_FETCH;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_state_nxt;
    end

    // Program counter and outstanding-request counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= '0;
            r_out_cnt <= '0;
        end else begin
            r_out_cnt <= w_out_nxt;
            if (bus.redirect)    r_pc <= bus.redirect_pc;
            else if (w_gnt_fire) r_pc <= r_pc + PC_W'(1);
        end
    end

    // Prefetch queue: circular buffer of {pc, word}, cleared on redirect/halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_rd  <= '0;
            r_q_wr  <= '0;
            r_q_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else if (w_qclr) begin
            r_q_rd  <= '0;
            r_q_wr  <= '0;
            r_q_cnt <= '0;
        end else begin
            if (w_push) begin
                r_q_data[r_q_wr] <= bus.imem_rdata;
                r_q_pc[r_q_wr]   <= w_rsp_pc;
                r_q_wr           <= r_q_wr + AW'(1);
            end
            if (w_pop) r_q_rd <= r_q_rd + AW'(1);
            r_q_cnt <= r_q_cnt + {{(CW-1){1'b0}}, w_push}
                               - {{(CW-1){1'b0}}, w_pop};
        end
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = (r_q_cnt != '0);
    assign bus.instruction = r_q_data[r_q_rd];
    assign bus.instr_pc    = r_q_pc[r_q_rd];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. A single-threaded cycle
// task drives memory and core, models response latency in grant order,
// and scoreboards delivered words against the expected address stream.
module tb_fetch_unit;
    localparam int PC_W  = 8;
    localparam int DEPTH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    fetch_unit_if #(.PC_W(PC_W)) bus ();

    fetch_unit #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc;
    int          gnt_mode;
    int          k_fix;
    logic        rdy;
    bit          rdy_pat;
    bit          halt_word;
    bit          no_deliver;
    logic [7:0]  exp_pc;
    int          n_deliv;
    int          first_deliv;
    int          n_gnt;
    int          max_pend;
    int          seen3;
    int          last_due;
    logic [7:0]  pend_a[$];
    int          pend_d[$];
    logic [7:0]  glog[$];
    logic [15:0] gpat = 16'b1011_0010_1101_0110;
    logic [7:0]  rpat = 8'b1101_1011;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return (halt_word && a == 8'd3) ? 16'hFC00 : {8'h10, a};
    endfunction

    // One clock cycle, entered and left just after a falling edge.
    task automatic step(input bit redir = 1'b0, input logic [7:0] rpc = 8'h00,
                        input bit spur = 1'b0);
        int k;
        int due;
        case (gnt_mode)
            0:       bus.imem_gnt = 1'b0;
            1:       bus.imem_gnt = 1'b1;
            default: bus.imem_gnt = gpat[cyc % 16];
        endcase
        if (pend_a.size() != 0 && pend_d[0] <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend_a[0]);
            void'(pend_a.pop_front());
            void'(pend_d.pop_front());
        end else if (spur) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 16'hDEAD;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 16'h0000;
        end
        bus.instr_ready = rdy_pat ? rpat[cyc % 8] : rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        #1;
        if (bus.imem_req && bus.imem_gnt) begin
            k   = (k_fix != 0) ? k_fix : 1 + (cyc % 4);
            due = cyc + k;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_a.push_back(bus.imem_addr);
            pend_d.push_back(due);
            glog.push_back(bus.imem_addr);
            n_gnt++;
        end
        if (pend_a.size() > max_pend) max_pend = pend_a.size();
        if (bus.instr_valid && bus.instr_ready) begin
            if (no_deliver) begin
                chk("deliver_while_halted", bus.instr_valid, 1'b0);
            end else begin
                chk("instr_pc", bus.instr_pc, exp_pc);
                chk("instruction", bus.instruction, mem_word(exp_pc));
            end
            if (halt_word && bus.instr_pc == 8'd3) seen3++;
            if (n_deliv == 0) first_deliv = cyc;
            n_deliv++;
            exp_pc = exp_pc + 8'd1;
        end
        if (redir) exp_pc = rpc;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 16'h0000;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 8'h00;
        #1;
        chk("rst_imem_req", bus.imem_req, 1'b0);
        chk("rst_imem_addr", bus.imem_addr, 8'h00);
        chk("rst_instr_valid", bus.instr_valid, 1'b0);
        chk("rst_instruction", bus.instruction, 16'h0000);
        chk("rst_instr_pc", bus.instr_pc, 8'h00);
        chk("rst_halted", bus.halted, 1'b0);
        pend_a.delete();
        pend_d.delete();
        glog.delete();
        exp_pc     = 8'h00;
        no_deliver = 1'b0;
        rdy_pat    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        cyc         = 0;
        last_due    = -1;
        n_deliv     = 0;
        first_deliv = -1;
        n_gnt       = 0;
        max_pend    = 0;
    endtask

    task automatic drain();
        int n;
        n        = 0;
        gnt_mode = 0;
        rdy_pat  = 1'b0;
        rdy      = 1'b1;
        while ((pend_a.size() != 0 || bus.instr_valid) && n < 40) begin
            step();
            n++;
        end
        chk("drain_empty", (pend_a.size() == 0) && !bus.instr_valid, 1'b1);
    endtask

    initial begin
        int         n0;
        int         n;
        int         nreq;
        logic [7:0] wa;
        gnt_mode   = 0;
        k_fix      = 1;
        rdy        = 1'b1;
        rdy_pat    = 1'b0;
        halt_word  = 1'b0;
        no_deliver = 1'b0;
        seen3      = 0;
        @(negedge clk);

        // streaming, one word per cycle after fill
        do_reset();
        gnt_mode = 1; k_fix = 1; rdy = 1'b1;
        repeat (12) step();
        chk("stream_first_cycle", first_deliv, 2);
        chk("stream_count", n_deliv, 10);

        // core stall: credit limits grants to DEPTH, head held
        do_reset();
        gnt_mode = 1; k_fix = 1; rdy = 1'b0;
        repeat (10) step();
        chk("stall_grants", n_gnt, 2);
        chk("stall_req_low", bus.imem_req, 1'b0);
        chk("stall_head_valid", bus.instr_valid, 1'b1);
        chk("stall_head_data", bus.instruction, 16'h1000);
        chk("stall_head_pc", bus.instr_pc, 8'h00);
        rdy = 1'b1;
        repeat (10) step();
        chk("stall_release_count", n_deliv, 10);

        // patterned grant, latency 1..4, patterned ready
        gnt_mode = 2; k_fix = 0; rdy_pat = 1'b1; max_pend = 0;
        n0 = n_deliv;
        repeat (60) step();
        chk("max_outstanding_le_depth", max_pend <= DEPTH, 1'b1);
        chk("pattern_delivered", n_deliv > n0, 1'b1);
        drain();

        // redirect with two outstanding
        gnt_mode = 1; k_fix = 4;
        step();
        step();
        chk("credit_block_req", bus.imem_req, 1'b0);
        step(1'b1, 8'h40);
        chk("redir_valid_low", bus.instr_valid, 1'b0);
        chk("redir_flush_req_low", bus.imem_req, 1'b0);
        n0 = n_deliv;
        repeat (16) step();
        chk("redir_delivered", n_deliv > n0, 1'b1);
        drain();

        // redirect coinciding with a grant
        gnt_mode = 1; k_fix = 3;
        chk("pre_redir_req", bus.imem_req, 1'b1);
        step(1'b1, 8'h50);
        chk("redir_gnt_flush_req_low", bus.imem_req, 1'b0);
        chk("redir_gnt_valid_low", bus.instr_valid, 1'b0);
        n0 = n_deliv;
        repeat (12) step();
        chk("redir_gnt_delivered", n_deliv > n0, 1'b1);
        drain();

        // PC wrap from 0xFE
        gnt_mode = 0; k_fix = 1;
        step(1'b1, 8'hFE);
        chk("wrap_req_next_cycle", bus.imem_req, 1'b1);
        chk("wrap_addr", bus.imem_addr, 8'hFE);
        gnt_mode = 1;
        glog.delete();
        repeat (4) step();
        chk("wrap_gnt_count", glog.size(), 4);
        wa = 8'hFE;
        for (int i = 0; i < 4 && i < glog.size(); i++) begin
            chk("wrap_gnt_addr", glog[i], wa);
            wa = wa + 8'd1;
        end
        repeat (4) step();
        drain();

        // response with nothing outstanding is ignored
        step(1'b0, 8'h00, 1'b1);
        chk("spur_no_valid", bus.instr_valid, 1'b0);
        gnt_mode = 1; k_fix = 2;
        n0 = n_deliv;
        repeat (8) step();
        chk("spur_then_stream", n_deliv > n0, 1'b1);

        // halt opcode at address 3, entered through a mid-stream reset
        do_reset();
        halt_word = 1'b1; seen3 = 0;
        gnt_mode = 1; k_fix = 1; rdy = 1'b1;
        n = 0;
        while (seen3 == 0 && n < 20) begin
            step();
            n++;
        end
        chk("halt_word_seen", seen3, 1);
`ifdef FETCH_HALT_EN
        chk("halted_set", bus.halted, 1'b1);
        chk("halt_req_low", bus.imem_req, 1'b0);
        chk("halt_valid_low", bus.instr_valid, 1'b0);
        no_deliver = 1'b1;
        nreq = 0;
        repeat (20) begin
            step();
            if (bus.imem_req) nreq++;
        end
        chk("halt_req_cycles", nreq, 0);
        chk("halt_still_halted", bus.halted, 1'b1);
        chk("halt_word_once", seen3, 1);
        step(1'b1, 8'h00);
        no_deliver = 1'b0;
        halt_word  = 1'b0;
        chk("halt_cleared", bus.halted, 1'b0);
        n0 = n_deliv;
        repeat (8) step();
        chk("halt_resume_delivered", n_deliv > n0, 1'b1);
`else
        chk("no_halt_flag", bus.halted, 1'b0);
        n0 = n_deliv;
        nreq = 0;
        repeat (6) begin
            step();
            if (bus.imem_req) nreq++;
        end
        chk("no_halt_continues", n_deliv > n0, 1'b1);
        chk("no_halt_req_active", nreq > 0, 1'b1);
        chk("no_halt_still", bus.halted, 1'b0);
        chk("halt_word_once", seen3, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
